// File: rtl/ffd_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ffd_write_arbiter_if
// Brief   : Requester-side bus of the shared-register write arbiter:
//           request/data inputs plus ack, owner, busy, register and counter.
// Revision: 1.0 - initial release
// ============================================================================
interface ffd_write_arbiter_if #(
   parameter int WORD_LENGTH = 4,
   parameter int NUM_REQ     = 4,
   parameter int COUNT_WIDTH = 8
);
   localparam int ID_WIDTH = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
   logic [NUM_REQ-1:0]             ack;
   logic [ID_WIDTH-1:0]            owner_id;
   logic                           busy;
   logic [WORD_LENGTH-1:0]         data_out;
   logic [COUNT_WIDTH-1:0]         write_count;

   // Requester side: drives requests and data, observes the results
   modport master (
      output req, req_data,
      input  ack, owner_id, busy, data_out, write_count
   );

   // Arbiter side
   modport slave (
      input  req, req_data,
      output ack, owner_id, busy, data_out, write_count
   );
endinterface
`default_nettype wire

// File: rtl/ffd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ffd_write_arbiter
// Brief   : Round-robin arbiter that shares one WORD_LENGTH-bit register
//           between NUM_REQ requesters. Each transaction is IDLE (arbitrate,
//           capture data) -> WRITE (commit) -> ACK (one-cycle acknowledge).
//           Optional macro FFD_ARB_LOCK_EN adds a lock input that lets the
//           current owner keep the register for back-to-back writes.
// Revision: 1.0 - initial release
// ============================================================================
module ffd_write_arbiter #(
   parameter int WORD_LENGTH = 4,
   parameter int NUM_REQ     = 4,
   parameter int COUNT_WIDTH = 8
) (
   input  logic clock,
   input  logic reset,
`ifdef FFD_ARB_LOCK_EN
   input  logic lock,
`endif
   ffd_write_arbiter_if.slave bus
);
   localparam int                  ID_WIDTH = $clog2(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t                 state;
   logic [ID_WIDTH-1:0]    rr_ptr;
   logic [ID_WIDTH-1:0]    owner_id;
   logic [ID_WIDTH-1:0]    winner;
   logic [ID_WIDTH-1:0]    next_ptr;
   logic [WORD_LENGTH-1:0] hold_data;
   logic [WORD_LENGTH-1:0] win_data;
   logic [WORD_LENGTH-1:0] data_reg;
   logic [NUM_REQ-1:0]     ack_reg;
   logic                   busy_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic                   start;
`ifdef FFD_ARB_LOCK_EN
   logic                   locked;
`endif

   // Winner search: scan downward over offsets so the smallest offset from
   // rr_ptr (highest priority) is the last to assign and therefore wins.
   always_comb begin
      winner = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(rr_ptr) + k) % NUM_REQ])
            winner = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      end
`ifdef FFD_ARB_LOCK_EN
      if (locked)
         winner = owner_id;
      start = (bus.req != '0) || locked;
`else
      start = (bus.req != '0);
`endif
      win_data = bus.req_data[int'(winner)*WORD_LENGTH +: WORD_LENGTH];
      next_ptr = (owner_id == LAST_ID) ? '0 : owner_id + ID_WIDTH'(1);
   end

   // Transaction sequencer, register bank and committed-write counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner_id  <= '0;
         hold_data <= '0;
         data_reg  <= '0;
         ack_reg   <= '0;
         busy_reg  <= 1'b0;
         count_reg <= '0;
`ifdef FFD_ARB_LOCK_EN
         locked    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  owner_id  <= winner;
                  hold_data <= win_data;
                  busy_reg  <= 1'b1;
                  state     <= WRITE;
`ifdef FFD_ARB_LOCK_EN
                  locked    <= 1'b0;
`endif
               end
            end
            WRITE: begin
               data_reg  <= hold_data;
               count_reg <= count_reg + COUNT_WIDTH'(1);
               ack_reg   <= NUM_REQ'(1) << owner_id;
               state     <= ACK;
            end
            ACK: begin
               ack_reg  <= '0;
               busy_reg <= 1'b0;
               state    <= IDLE;
`ifdef FFD_ARB_LOCK_EN
               // A locked owner keeps rr_ptr where it is and is re-granted
               if (lock && bus.req[owner_id])
                  locked <= 1'b1;
               else
                  rr_ptr <= next_ptr;
`else
               rr_ptr <= next_ptr;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack         = ack_reg;
   assign bus.owner_id    = owner_id;
   assign bus.busy        = busy_reg;
   assign bus.data_out    = data_reg;
   assign bus.write_count = count_reg;

endmodule
`default_nettype wire

// File: tb/tb_ffd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ffd_write_arbiter
// Brief   : Directed self-checking bench for ffd_write_arbiter. A second
//           instance with a 2-bit counter shares the stimulus to exercise
//           counter wrap. Lock sequence is built when FFD_ARB_LOCK_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ffd_write_arbiter;
   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_data;
`ifdef FFD_ARB_LOCK_EN
   logic        lock;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   int n;

   ffd_write_arbiter_if #(.WORD_LENGTH(4), .NUM_REQ(4), .COUNT_WIDTH(8)) bus  ();
   ffd_write_arbiter_if #(.WORD_LENGTH(4), .NUM_REQ(4), .COUNT_WIDTH(2)) bus2 ();

   assign bus.req       = req;
   assign bus.req_data  = req_data;
   assign bus2.req      = req;
   assign bus2.req_data = req_data;

   ffd_write_arbiter #(.WORD_LENGTH(4), .NUM_REQ(4), .COUNT_WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
`ifdef FFD_ARB_LOCK_EN
      .lock  (lock),
`endif
      .bus   (bus)
   );

   ffd_write_arbiter #(.WORD_LENGTH(4), .NUM_REQ(4), .COUNT_WIDTH(2)) dut_wrap (
      .clock (clock),
      .reset (reset),
`ifdef FFD_ARB_LOCK_EN
      .lock  (lock),
`endif
      .bus   (bus2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for an ack, then check the committed transaction
   task automatic wait_ack(input int exp_id, input logic [3:0] exp_data,
                           input string tag, output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (bus.ack == 4'b0 && cycles < 20);
      exp_cnt++;
      check({tag, "_ack"},   bus.ack,         32'(1 << exp_id));
      check({tag, "_data"},  bus.data_out,    exp_data);
      check({tag, "_owner"}, bus.owner_id,    exp_id);
      check({tag, "_busy"},  bus.busy,        1);
      check({tag, "_cnt"},   bus.write_count, exp_cnt % 256);
      check({tag, "_wrap"},  bus2.write_count, exp_cnt % 4);
   endtask

   logic [3:0] cdata [4];

   initial begin
      cdata[0] = 4'h1; cdata[1] = 4'h3; cdata[2] = 4'h5; cdata[3] = 4'h9;
      reset    = 1'b1;
      req      = 4'b1111;
      req_data = 16'h9531;
`ifdef FFD_ARB_LOCK_EN
      lock     = 1'b0;
`endif
      // Reset held for two edges with all requests pending
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_data",  bus.data_out,    0);
      check("rst_ack",   bus.ack,         0);
      check("rst_cnt",   bus.write_count, 0);
      check("rst_busy",  bus.busy,        0);
      check("rst_owner", bus.owner_id,    0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Full contention: 0,1,2,3,0 at 3-cycle spacing; wrap counter 1,2,3,0,1
      for (int i = 0; i < 5; i++) begin
         wait_ack(i % 4, cdata[i % 4], "rr", n);
         check("rr_gap", n, 3);
      end
      req = 4'b0000;
      repeat (3) @(negedge clock);
      check("idle_busy", bus.busy,     0);
      check("idle_ack",  bus.ack,      0);
      check("idle_hold", bus.data_out, 4'h1);

      // Single request from requester 2
      req      = 4'b0100;
      req_data = 16'h0500;
      @(negedge clock);
      check("single_t1_busy", bus.busy,     1);
      check("single_t1_ack",  bus.ack,      0);
      check("single_t1_data", bus.data_out, 4'h1);
      wait_ack(2, 4'h5, "single", n);
      check("single_lat", n, 1);
      req = 4'b0000;
      @(negedge clock);
      check("single_pulse", bus.ack,      0);
      check("single_idle",  bus.busy,     0);
      check("single_hold",  bus.data_out, 4'h5);

      // Reset during WRITE discards the pending write
      req      = 4'b0010;
      req_data = 16'h0030;
      @(negedge clock);
      check("mid_busy", bus.busy, 1);
      reset = 1'b1;
      @(negedge clock);
      exp_cnt = 0;
      check("mid_data", bus.data_out,     0);
      check("mid_ack",  bus.ack,          0);
      check("mid_cnt",  bus.write_count,  0);
      check("mid_wrap", bus2.write_count, 0);
      check("mid_busy0", bus.busy,        0);

      // Pointer is back at 0 after reset: requester 0 beats requester 3
      reset    = 1'b0;
      req      = 4'b1001;
      req_data = 16'h7002;
      wait_ack(0, 4'h2, "post_rst", n);
      req = 4'b1000;
      wait_ack(3, 4'h7, "post_next", n);
      check("post_gap", n, 3);
      req = 4'b0000;
      repeat (2) @(negedge clock);

`ifdef FFD_ARB_LOCK_EN
      // Lock keeps requester 0 for three writes, then 1 gets its turn
      req      = 4'b0011;
      req_data = 16'h00A6;
      lock     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ack(0, 4'h6, "lock", n);
      end
      lock = 1'b0;
      wait_ack(1, 4'hA, "unlock", n);
      check("unlock_gap", n, 3);
      req = 4'b0000;
      repeat (2) @(negedge clock);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
